// File: rtl/lane_deskew.sv
`timescale 1ps/1ps
//-----------------------------------------------------------------------------
// lane_deskew
//
// Multi-lane programmable-delay register array. Each lane runs its data
// through a DEPTH-entry shift register and forwards the entry chosen by that
// lane's active delay, so lanes with different arrival skew line up at the
// output. Delay changes are loaded atomically with a single-cycle dly_load
// pulse. The block then blanks dout_valid, asserts dly_busy and waits DEPTH
// cycles until every tap again holds valid history.
//
// Parameters:
//   LANES   number of independent lanes
//   WIDTH   bits per lane per cycle
//   DEPTH   delay-line entries per lane (>= 2); maximum delay is DEPTH-1
//   T_CLKQ  clock-to-q delay in ps for every registered output. It is
//           annotated as a path delay in the specify block, not as logic.
//   SELW    derived, $clog2(DEPTH): width of one lane's delay select
//
// Ports:
//   clk         clock
//   rstb        asynchronous active-low reset
//   din         lane data, lane i at [i*WIDTH +: WIDTH]
//   dly_sel     requested delay per lane, lane i at [i*SELW +: SELW]
//   dly_load    single-cycle pulse that captures dly_sel
//   dly_busy    high while the fill state machine is in FILL
//   dout        delayed lane data, registered
//   dout_valid  high when dout reflects the active delay settings
//   bypass      present only with LANE_DESKEW_BYPASS_EN defined. It forces
//               latency 1 on all lanes and holds dout_valid high.
//
// Optional feature macro: LANE_DESKEW_BYPASS_EN
//-----------------------------------------------------------------------------
module lane_deskew #(
  parameter  int  LANES  = 16,
  parameter  int  WIDTH  = 1,
  parameter  int  DEPTH  = 8,
  parameter  real T_CLKQ = 5.0,
  localparam int  SELW   = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rstb,
  input  logic [LANES*WIDTH-1:0] din,
  input  logic [LANES*SELW-1:0]  dly_sel,
  input  logic                   dly_load,
  output logic                   dly_busy,
  output logic [LANES*WIDTH-1:0] dout,
  output logic                   dout_valid
`ifdef LANE_DESKEW_BYPASS_EN
  ,
  input  logic                   bypass
`endif
);

  // Largest legal delay. It is also the last value of the fill counter.
  localparam logic [SELW-1:0] SEL_MAX = SELW'(DEPTH - 1);

  typedef enum logic {
    S_FILL = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  // Elaboration-time parameter sanity checks.
  if (DEPTH < 2) begin : g_depth_chk
    $error("lane_deskew: DEPTH must be 2 or more");
  end
  if (T_CLKQ < 0.0) begin : g_tclkq_chk
    $error("lane_deskew: T_CLKQ must not be negative");
  end

  // Clamp a captured select to the deepest existing tap. A select can only
  // exceed DEPTH-1 when DEPTH is not a power of two.
  function automatic logic [SELW-1:0] clamp_sel(input logic [SELW-1:0] s);
    if (int'(s) > DEPTH - 1) return SEL_MAX;
    return s;
  endfunction

  //---------------------------------------------------------------------------
  // Delay lines: entry 0 captures din every cycle and the line shifts every
  // cycle. A load never flushes them.
  //---------------------------------------------------------------------------
  logic [WIDTH-1:0] sr_q [LANES][DEPTH];

  // NOTE: this storage is reset on purpose. dout must read 0 after reset
  // until real data has propagated, and that only holds if every tap starts
  // at 0. Reset costs a reset pin per flop, so plain data RAMs normally skip
  // it.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      for (int i = 0; i < LANES; i++) begin
        for (int k = 0; k < DEPTH; k++) begin
          sr_q[i][k] <= '0;
        end
      end
    end else begin
      // NOTE: non-blocking assignments make every entry read its
      // neighbour's pre-edge value, so the line shifts by exactly one
      // position per clock. Blocking assignments would ripple din through
      // the whole line in a single cycle.
      for (int i = 0; i < LANES; i++) begin
        sr_q[i][0] <= din[i*WIDTH +: WIDTH];
        for (int k = 1; k < DEPTH; k++) begin
          sr_q[i][k] <= sr_q[i][k-1];
        end
      end
    end
  end

  //---------------------------------------------------------------------------
  // Active per-lane delays. They are captured on every load edge. The
  // output mux sees the new tap one edge later.
  //---------------------------------------------------------------------------
  logic [SELW-1:0] d_q [LANES];

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      for (int i = 0; i < LANES; i++) begin
        d_q[i] <= '0;
      end
    end else if (dly_load) begin
      for (int i = 0; i < LANES; i++) begin
        d_q[i] <= clamp_sel(dly_sel[i*SELW +: SELW]);
      end
    end
  end

  //---------------------------------------------------------------------------
  // Output tap mux and output register.
  // Tap d gives dout at edge n = din sampled at edge n-1-d.
  //---------------------------------------------------------------------------
  logic [LANES*WIDTH-1:0] dout_d;
  logic [LANES*WIDTH-1:0] dout_q;

  always_comb begin
    // NOTE: assigning a default before the loop means every bit of dout_d is
    // written on every pass through this block. Without it, a bit left
    // unassigned on some path would be inferred as a latch.
    dout_d = '0;
    for (int i = 0; i < LANES; i++) begin
`ifdef LANE_DESKEW_BYPASS_EN
      dout_d[i*WIDTH +: WIDTH] = bypass ? sr_q[i][0] : sr_q[i][d_q[i]];
`else
      dout_d[i*WIDTH +: WIDTH] = sr_q[i][d_q[i]];
`endif
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      dout_q <= '0;
    end else begin
      dout_q <= dout_d;
    end
  end

  //---------------------------------------------------------------------------
  // Fill state machine.
  //
  // cnt_q counts elapsed fill edges upward from 0. The remaining fill count
  // is DEPTH-1-cnt_q, so the reset value 0 already means "DEPTH-1 edges to
  // go". That gives the same fill length after reset release as after a
  // load: dout_valid rises DEPTH edges later in both cases.
  //---------------------------------------------------------------------------
  state_e          state_q;
  logic [SELW-1:0] cnt_q;
  logic            dly_busy_q;
  logic            dout_valid_q;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q      <= S_FILL;
      cnt_q        <= '0;
      dly_busy_q   <= 1'b1;
      dout_valid_q <= 1'b0;
    end else begin
      if (dly_load) begin
        // A load in either state restarts the fill, and the last load wins.
        state_q      <= S_FILL;
        cnt_q        <= '0;
        dly_busy_q   <= 1'b1;
        dout_valid_q <= 1'b0;
      end else begin
        case (state_q)
          S_FILL: begin
            if (cnt_q == SEL_MAX) begin
              state_q      <= S_RUN;
              dly_busy_q   <= 1'b0;
              dout_valid_q <= 1'b1;
            end else begin
              cnt_q        <= cnt_q + 1'b1;
              dly_busy_q   <= 1'b1;
              dout_valid_q <= 1'b0;
            end
          end
          S_RUN: begin
            dly_busy_q   <= 1'b0;
            dout_valid_q <= 1'b1;
          end
          default: begin
            state_q      <= S_FILL;
            cnt_q        <= '0;
            dly_busy_q   <= 1'b1;
            dout_valid_q <= 1'b0;
          end
        endcase
      end
`ifdef LANE_DESKEW_BYPASS_EN
      // Bypass only needs tap 0, which always holds fresh data, so valid is
      // held high. The fill sequence still runs underneath.
      if (bypass) dout_valid_q <= 1'b1;
`endif
    end
  end

  assign dout       = dout_q;
  assign dly_busy   = dly_busy_q;
  assign dout_valid = dout_valid_q;

  //---------------------------------------------------------------------------
  // Timing annotation: setup/hold of the sampled inputs against clk, and the
  // clock-to-q delay of the registered outputs.
  //---------------------------------------------------------------------------
  specify
    specparam t_setup = 5, t_hold = 2;
    $setup(din,      posedge clk, t_setup);
    $setup(dly_sel,  posedge clk, t_setup);
    $setup(dly_load, posedge clk, t_setup);
    $hold(posedge clk, din,      t_hold);
    $hold(posedge clk, dly_sel,  t_hold);
    $hold(posedge clk, dly_load, t_hold);
    (clk *> dout)       = T_CLKQ;
    (clk *> dly_busy)   = T_CLKQ;
    (clk *> dout_valid) = T_CLKQ;
  endspecify

endmodule

// File: tb/tb_lane_deskew.sv
`timescale 1ps/1ps
module tb_lane_deskew;

  localparam int LANES = 4;
  localparam int DEPTH = 8;
  localparam int SELW  = 3;
  localparam int L6    = 2;
  localparam int D6    = 6;
  localparam int SELW6 = 3;

  logic clk  = 1'b0;
  logic rstb = 1'b0;

  // Main instance: 4 lanes, DEPTH 8.
  logic [LANES-1:0]      din;
  logic [LANES*SELW-1:0] dly_sel;
  logic                  dly_load;
  logic                  dly_busy;
  logic [LANES-1:0]      dout;
  logic                  dout_valid;

  // Clamp instance: 2 lanes, DEPTH 6.
  logic [L6-1:0]       din6;
  logic [L6*SELW6-1:0] dly_sel6;
  logic                dly_load6;
  logic                dly_busy6;
  logic [L6-1:0]       dout6;
  logic                dout_valid6;

`ifdef LANE_DESKEW_BYPASS_EN
  logic bypass = 1'b0;
`endif

  lane_deskew #(.LANES(LANES), .WIDTH(1), .DEPTH(DEPTH), .T_CLKQ(5.0)) dut (
    .clk        (clk),
    .rstb       (rstb),
    .din        (din),
    .dly_sel    (dly_sel),
    .dly_load   (dly_load),
    .dly_busy   (dly_busy),
    .dout       (dout),
    .dout_valid (dout_valid)
`ifdef LANE_DESKEW_BYPASS_EN
    ,
    .bypass     (bypass)
`endif
  );

  lane_deskew #(.LANES(L6), .WIDTH(1), .DEPTH(D6), .T_CLKQ(5.0)) dut6 (
    .clk        (clk),
    .rstb       (rstb),
    .din        (din6),
    .dly_sel    (dly_sel6),
    .dly_load   (dly_load6),
    .dly_busy   (dly_busy6),
    .dout       (dout6),
    .dout_valid (dout_valid6)
`ifdef LANE_DESKEW_BYPASS_EN
    ,
    .bypass     (bypass)
`endif
  );

  always #500 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Advance one posedge and sample 100 ps after it.
  task automatic tick();
    @(posedge clk);
    #100;
  endtask

  task automatic load(input logic [LANES*SELW-1:0] sel);
    dly_sel  = sel;
    dly_load = 1'b1;
    tick();
    dly_load = 1'b0;
  endtask

  // Checks the FILL window after a load or reset release: valid only on the
  // DEPTH-th edge.
  task automatic expect_fill(input string name);
    for (int e = 1; e <= DEPTH; e++) begin
      tick();
      check({name, " valid"}, 16'(dout_valid), 16'(e == DEPTH));
      check({name, " busy"},  16'(dly_busy),   16'(e != DEPTH));
    end
  endtask

  // One-cycle pulse on all lanes. Every lane must show it exactly lat edges
  // after the edge that samples it.
  task automatic pulse_probe(input string name, input int lat);
    din = 4'hF;
    tick();
    din = 4'h0;
    check({name, " k0"}, 16'(dout), 16'h0);
    for (int k = 1; k <= DEPTH + 1; k++) begin
      tick();
      check($sformatf("%s k%0d", name, k), 16'(dout),
            (k == lat) ? 16'h000F : 16'h0000);
    end
  endtask

  typedef struct {
    logic [3:0] din;
    logic [3:0] dout;
    logic       valid;
    logic       busy;
  } vec_t;

  vec_t tbl [10];

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    // Walking pulse on all lanes with delays {7,5,3,0} for lanes {3,2,1,0}.
    // Lane i sees the pulse 1+d_i edges after the edge that samples it.
    tbl[0] = '{4'hF, 4'h0, 1'b1, 1'b0};
    tbl[1] = '{4'h0, 4'h1, 1'b1, 1'b0};
    tbl[2] = '{4'h0, 4'h0, 1'b1, 1'b0};
    tbl[3] = '{4'h0, 4'h0, 1'b1, 1'b0};
    tbl[4] = '{4'h0, 4'h2, 1'b1, 1'b0};
    tbl[5] = '{4'h0, 4'h0, 1'b1, 1'b0};
    tbl[6] = '{4'h0, 4'h4, 1'b1, 1'b0};
    tbl[7] = '{4'h0, 4'h0, 1'b1, 1'b0};
    tbl[8] = '{4'h0, 4'h8, 1'b1, 1'b0};
    tbl[9] = '{4'h0, 4'h0, 1'b1, 1'b0};

    din = '0; dly_sel = '0; dly_load = 1'b0;
    din6 = '0; dly_sel6 = '0; dly_load6 = 1'b0;

    // ---- Reset and fill ----
    #1250;
    check("rst dout",  16'(dout),       16'h0);
    check("rst busy",  16'(dly_busy),   16'h1);
    check("rst valid", 16'(dout_valid), 16'h0);
    @(negedge clk);
    rstb = 1'b1;
    for (int e = 1; e <= DEPTH; e++) begin
      tick();
      check($sformatf("fill e%0d valid", e), 16'(dout_valid), 16'(e == DEPTH));
      check($sformatf("fill e%0d busy", e),  16'(dly_busy),   16'(e != DEPTH));
      check($sformatf("fill e%0d dout", e),  16'(dout),       16'h0);
    end

    // ---- Per-lane delays 0,3,5,7 ----
    load({3'd7, 3'd5, 3'd3, 3'd0});
    check("load busy",  16'(dly_busy),   16'h1);
    check("load valid", 16'(dout_valid), 16'h0);
    expect_fill("perlane fill");
    for (int k = 0; k < 10; k++) begin
      din = tbl[k].din;
      tick();
      check($sformatf("tbl%0d dout", k),  16'(dout),       16'(tbl[k].dout));
      check($sformatf("tbl%0d valid", k), 16'(dout_valid), 16'(tbl[k].valid));
      check($sformatf("tbl%0d busy", k),  16'(dly_busy),   16'(tbl[k].busy));
    end
    din = '0;

    // ---- Reload mid-FILL: 2s, then 6s three edges later ----
    load({3'd2, 3'd2, 3'd2, 3'd2});
    tick();
    tick();
    check("reload mid valid", 16'(dout_valid), 16'h0);
    load({3'd6, 3'd6, 3'd6, 3'd6});
    check("reload busy", 16'(dly_busy), 16'h1);
    expect_fill("reload fill");
    pulse_probe("reload lat7", 7);

    // ---- Clamp: DEPTH 6, lane0 sel 7 -> delay 5, lane1 sel 2 ----
    dly_sel6  = {3'd2, 3'd7};
    dly_load6 = 1'b1;
    tick();
    dly_load6 = 1'b0;
    check("clamp busy", 16'(dly_busy6), 16'h1);
    for (int e = 1; e <= D6; e++) begin
      tick();
      check($sformatf("clamp fill e%0d", e), 16'(dout_valid6), 16'(e == D6));
    end
    din6 = 2'b11;
    tick();
    din6 = 2'b00;
    for (int k = 1; k <= D6 + 2; k++) begin
      tick();
      check($sformatf("clamp k%0d", k), 16'(dout6), 16'({k == 3, k == 6}));
    end

    // ---- Async reset mid-RUN ----
    din = 4'hF;
    for (int e = 0; e < DEPTH; e++) tick();
    check("pre-rst dout",  16'(dout),       16'h000F);
    check("pre-rst valid", 16'(dout_valid), 16'h1);
    #200;
    rstb = 1'b0;
    #10;
    check("async rst dout",  16'(dout),       16'h0);
    check("async rst valid", 16'(dout_valid), 16'h0);
    check("async rst busy",  16'(dly_busy),   16'h1);
    din = 4'h0;
    @(negedge clk);
    rstb = 1'b1;
    expect_fill("post-rst fill");
    pulse_probe("post-rst lat1", 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
